bp_be_stride_detector: RTL and testbench

- Upstream feeder of the backend loop-inference unit.
- Watches committed loads, trains a small per-PC stride table, and picks one striding load at a time.
- Drives the inference unit's start-discovery / confirm-discovery / striding-PC inputs, then holds that load until the inference result is consumed.
- Sits in bp_be_checker beside the inference unit and is fed from the commit-side load path.

---
 rtl/bp_be_stride_detector_pkg.sv | 28 ++
 rtl/bp_be_stride_detector_if.sv | 31 +++
 rtl/bp_be_stride_detector_table.sv | 99 +++++++++
 rtl/bp_be_stride_detector.sv | 127 ++++++++++++
 tb/tb_bp_be_stride_detector.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_stride_detector_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_be_stride_detector_pkg : config, FSM state and confidence constants
// Revision 1.0
// ----------------------------------------------------------------------------
package bp_be_stride_detector_pkg;

   typedef enum logic [0:0] {
      e_bp_default_cfg = 1'b0
   } bp_params_e;

   typedef enum logic [1:0] {
      e_sd_idle      = 2'd0,
      e_sd_discover  = 2'd1,
      e_sd_confirmed = 2'd2
   } bp_be_stride_state_e;

   localparam logic [1:0] sd_conf_sat_gp = 2'd3;

   function automatic int bp_vaddr_width(bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 39;
         default:          return 39;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_be_stride_detector_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_be_stride_detector_if : commit-load feed and inference-unit handshake
// Revision 1.0
// ----------------------------------------------------------------------------
interface bp_be_stride_detector_if #(
   parameter int vaddr_width_p  = 39,
   parameter int stride_width_p = 16
);
   logic                      ld_v_i;
   logic [vaddr_width_p-1:0]  ld_pc_i;
   logic [vaddr_width_p-1:0]  ld_vaddr_i;
   logic                      start_discovery_o;
   logic                      confirm_discovery_o;
   logic [vaddr_width_p-1:0]  striding_pc_o;
   logic [stride_width_p-1:0] stride_o;
   logic                      infer_v_i;
   logic                      infer_yumi_o;

   modport master (
      output ld_v_i, ld_pc_i, ld_vaddr_i, infer_v_i,
      input  start_discovery_o, confirm_discovery_o, striding_pc_o, stride_o, infer_yumi_o
   );

   modport slave (
      input  ld_v_i, ld_pc_i, ld_vaddr_i, infer_v_i,
      output start_discovery_o, confirm_discovery_o, striding_pc_o, stride_o, infer_yumi_o
   );

endinterface
`default_nettype wire

// File: rtl/bp_be_stride_detector_table.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_be_stride_table : direct-mapped per-PC stride table (BP_BE_STRIDE_NEG_EN)
// Revision 1.0
// ----------------------------------------------------------------------------
module bp_be_stride_table
   import bp_be_stride_detector_pkg::*;
#(
   parameter int vaddr_width_p  = 39,
   parameter int entries_p      = 8,
   parameter int stride_width_p = 16
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic                             ld_v_i,
   input  logic [vaddr_width_p-1:2]         ld_pc_i,
   input  logic [vaddr_width_p-1:0]         ld_vaddr_i,
   output logic                             hit_o,
   output logic [1:0]                       conf_o,
   output logic signed [stride_width_p-1:0] stride_o
);

   localparam int idx_w_lp = $clog2(entries_p);
   localparam int tag_w_lp = vaddr_width_p - idx_w_lp - 2;

   // Widths follow the module parameters, so the entry layout lives here.
   typedef struct packed {
      logic                             v;
      logic [tag_w_lp-1:0]              tag;
      logic [vaddr_width_p-1:0]         last_addr;
      logic signed [stride_width_p-1:0] stride;
      logic [1:0]                       conf;
   } bp_be_stride_entry_s;

   bp_be_stride_entry_s                   tbl_w [entries_p];
   bp_be_stride_entry_s                   entry_r;
   bp_be_stride_entry_s                   entry_d;
   logic [idx_w_lp-1:0]                   idx;
   logic [tag_w_lp-1:0]                   tag;
   logic [vaddr_width_p-1:0]              delta;
   logic [vaddr_width_p-stride_width_p:0] delta_hi;
   logic                                  delta_ok;
   logic                                  stride_match;

   assign idx      = ld_pc_i[idx_w_lp+1:2];
   assign tag      = ld_pc_i[vaddr_width_p-1:idx_w_lp+2];
   assign entry_r  = tbl_w[idx];
   assign hit_o    = entry_r.v && (entry_r.tag == tag);
   assign delta    = ld_vaddr_i - entry_r.last_addr;
   assign delta_hi = delta[vaddr_width_p-1:stride_width_p-1];

   // A delta is usable only if it sign-fits the stride field.
`ifdef BP_BE_STRIDE_NEG_EN
   assign delta_ok = (&delta_hi) | ~(|delta_hi);
`else
   assign delta_ok = ~(|delta_hi);
`endif

   assign stride_match = delta_ok && (|entry_r.stride)
                      && (entry_r.stride == delta[stride_width_p-1:0]);

   always_comb begin
      entry_d = entry_r;
      if (!hit_o) begin
         entry_d.v         = 1'b1;
         entry_d.tag       = tag;
         entry_d.last_addr = ld_vaddr_i;
         entry_d.stride    = '0;
         entry_d.conf      = 2'd0;
      end else begin
         entry_d.last_addr = ld_vaddr_i;
         if (stride_match) begin
            entry_d.conf = (entry_r.conf == sd_conf_sat_gp) ? entry_r.conf
                                                           : entry_r.conf + 2'd1;
         end else begin
            entry_d.stride = delta_ok ? delta[stride_width_p-1:0] : '0;
            entry_d.conf   = 2'd0;
         end
      end
   end

   assign conf_o   = entry_d.conf;
   assign stride_o = entry_d.stride;

   for (genvar i = 0; i < entries_p; i++) begin : g_entry
      bp_be_stride_entry_s entry_q;

      always_ff @(posedge clk_i) begin
         if (!reset_n_i)
            entry_q.v <= 1'b0;
         else if (ld_v_i && (idx == idx_w_lp'(i)))
            entry_q <= entry_d;
      end

      assign tbl_w[i] = entry_q;
   end

endmodule
`default_nettype wire

// File: rtl/bp_be_stride_detector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_be_stride_detector : picks one striding load for loop inference (BP_BE_STRIDE_NEG_EN)
// Revision 1.0
// ----------------------------------------------------------------------------
module bp_be_stride_detector
   import bp_be_stride_detector_pkg::*;
#(
   parameter bp_params_e bp_params_p    = e_bp_default_cfg,
   parameter int         entries_p      = 8,
   parameter int         stride_width_p = 16,
   parameter int         conf_thresh_p  = 3,
   parameter int         timeout_p      = 64,
   localparam int        vaddr_width_p  = bp_vaddr_width(bp_params_p)
) (
   input logic                    clk_i,
   input logic                    reset_n_i,
   bp_be_stride_detector_if.slave sd_if
);

   localparam int                  idx_w_lp    = $clog2(entries_p);
   localparam int                  cnt_w_lp    = $clog2(timeout_p);
   localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(timeout_p - 1);
   localparam logic [1:0]          thresh_lp   = 2'(conf_thresh_p);

   bp_be_stride_state_e              state_q, state_d;
   logic                             start_q, start_d;
   logic                             confirm_q, confirm_d;
   logic [vaddr_width_p-1:0]         pc_q, pc_d;
   logic signed [stride_width_p-1:0] stride_q, stride_d;
   logic [cnt_w_lp-1:0]              cnt_q, cnt_d;
   logic                             yumi;
   logic                             tbl_hit;
   logic [1:0]                       tbl_conf;
   logic signed [stride_width_p-1:0] tbl_stride;
   logic                             same_idx;
   logic                             same_entry;
   logic                             sel_confirm;
   logic                             sel_abort;

   bp_be_stride_table #(
      .vaddr_width_p  (vaddr_width_p),
      .entries_p      (entries_p),
      .stride_width_p (stride_width_p)
   ) u_table (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .ld_v_i     (sd_if.ld_v_i),
      .ld_pc_i    (sd_if.ld_pc_i[vaddr_width_p-1:2]),
      .ld_vaddr_i (sd_if.ld_vaddr_i),
      .hit_o      (tbl_hit),
      .conf_o     (tbl_conf),
      .stride_o   (tbl_stride)
   );

   // The selected load is identified by its table slot, so an alias to the
   // same index means its training history has just been overwritten.
   assign same_idx    = sd_if.ld_pc_i[idx_w_lp+1:2] == pc_q[idx_w_lp+1:2];
   assign same_entry  = sd_if.ld_pc_i[vaddr_width_p-1:2] == pc_q[vaddr_width_p-1:2];
   assign sel_confirm = same_entry && tbl_hit && (tbl_conf >= thresh_lp);
   assign sel_abort   = same_idx && (!same_entry || !tbl_hit || (tbl_conf == 2'd0));

   always_comb begin
      state_d   = state_q;
      start_d   = 1'b0;
      confirm_d = 1'b0;
      pc_d      = pc_q;
      stride_d  = stride_q;
      cnt_d     = cnt_q;
      yumi      = 1'b0;
      case (state_q)
         e_sd_idle: begin
            if (sd_if.ld_v_i && tbl_hit && (tbl_conf == 2'd1)) begin
               state_d  = e_sd_discover;
               start_d  = 1'b1;
               pc_d     = sd_if.ld_pc_i;
               stride_d = tbl_stride;
               cnt_d    = '0;
            end
         end
         e_sd_discover: begin
            if (sd_if.ld_v_i) begin
               cnt_d = cnt_q + 1'b1;
               if (sel_confirm) begin
                  state_d   = e_sd_confirmed;
                  confirm_d = 1'b1;
               end else if (sel_abort || (cnt_q == cnt_last_lp)) begin
                  state_d = e_sd_idle;
               end
            end
         end
         e_sd_confirmed: begin
            if (sd_if.infer_v_i) begin
               yumi    = 1'b1;
               state_d = e_sd_idle;
            end
         end
         default: state_d = e_sd_idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q   <= e_sd_idle;
         start_q   <= 1'b0;
         confirm_q <= 1'b0;
         pc_q      <= '0;
         stride_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         start_q   <= start_d;
         confirm_q <= confirm_d;
         pc_q      <= pc_d;
         stride_q  <= stride_d;
         cnt_q     <= cnt_d;
      end
   end

   assign sd_if.start_discovery_o   = start_q;
   assign sd_if.confirm_discovery_o = confirm_q;
   assign sd_if.striding_pc_o       = pc_q;
   assign sd_if.stride_o            = stride_q;
   assign sd_if.infer_yumi_o        = yumi;

endmodule
`default_nettype wire

// File: tb/tb_bp_be_stride_detector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bp_be_stride_detector : random loads vs. a behavioural stride model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_bp_be_stride_detector;
   import bp_be_stride_detector_pkg::*;

   localparam int VW      = 39;
   localparam int SW      = 16;
   localparam int ENTRIES = 8;
   localparam int THRESH  = 3;
   localparam int TIMEOUT = 64;
   localparam int N_ITER  = 6000;
   localparam int K_START = 1, K_CONFIRM = 2, K_YUMI = 4, K_ZERO = 8;
   localparam int M_IDLE = 0, M_DISC = 1, M_CONF = 2;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   bp_be_stride_detector_if #(.vaddr_width_p(VW), .stride_width_p(SW)) sd_if ();

   bp_be_stride_detector #(
      .bp_params_p    (e_bp_default_cfg),
      .entries_p      (ENTRIES),
      .stride_width_p (SW),
      .conf_thresh_p  (THRESH),
      .timeout_p      (TIMEOUT)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .sd_if     (sd_if)
   );

   typedef struct {
      int          idx;
      int          kind;
      logic [VW-1:0] pc;
      int          stride;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp   = 0;
   int   n_err   = 0;
   int   neg_idx = 0;

   // Reference model: table contents as plain numbers, plus the chosen load.
   bit     m_v      [ENTRIES];
   longint m_tag    [ENTRIES];
   longint m_last   [ENTRIES];
   int     m_stride [ENTRIES];
   int     m_conf   [ENTRIES];
   int     m_mode;
   longint m_sel_pc;
   int     m_sel_stride;
   int     m_cnt;

   task automatic push(input int idx, input int kind, input longint pc, input int stride);
      exp_t e;
      e.idx    = idx;
      e.kind   = kind;
      e.pc     = VW'(pc);
      e.stride = stride;
      exp_q.push_back(e);
   endtask

   task automatic model_step(input bit rst_n, input bit ldv, input longint pc,
                             input longint va, input bit iv, input int base);
      int     e, se, conf_new, stride_new;
      longint tag, d;
      bit     hit, fits, yumi, sel_ok, to_sel;
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
         m_mode = M_IDLE; m_sel_pc = 0; m_sel_stride = 0; m_cnt = 0;
         push(base + 2, K_ZERO, 0, 0);
         return;
      end
      yumi = (m_mode == M_CONF) && iv;
      if (yumi) push(base + 1, K_YUMI, 0, 0);
      if (m_mode == M_CONF) begin
         if (yumi) m_mode = M_IDLE;
      end
      if (!ldv) return;
      e   = int'((pc >> 2) % ENTRIES);
      tag = pc >> 5;
      hit = m_v[e] && (m_tag[e] == tag);
      conf_new = 0; stride_new = 0;
      if (hit) begin
         d = va - m_last[e];
`ifdef BP_BE_STRIDE_NEG_EN
         fits = (d >= -32768) && (d <= 32767);
`else
         fits = (d >= 0) && (d <= 32767);
`endif
         if (fits && d == m_stride[e] && m_stride[e] != 0) begin
            conf_new   = (m_conf[e] < 3) ? m_conf[e] + 1 : 3;
            stride_new = m_stride[e];
         end else begin
            stride_new = fits ? int'(d) : 0;
         end
      end
      m_v[e] = 1'b1; m_tag[e] = tag; m_last[e] = va;
      m_stride[e] = stride_new; m_conf[e] = conf_new;

      if (m_mode == M_IDLE && !yumi) begin
         if (conf_new == 1) begin
            m_mode = M_DISC; m_sel_pc = pc; m_sel_stride = stride_new; m_cnt = 0;
            push(base + 2, K_START, pc, stride_new);
         end
      end else if (m_mode == M_DISC) begin
         m_cnt++;
         se     = int'((m_sel_pc >> 2) % ENTRIES);
         to_sel = (pc >> 2) == (m_sel_pc >> 2);
         sel_ok = m_v[se] && m_tag[se] == (m_sel_pc >> 5) && m_conf[se] > 0;
         if (to_sel && m_conf[se] >= THRESH) begin
            m_mode = M_CONF;
            push(base + 2, K_CONFIRM, m_sel_pc, m_sel_stride);
         end else if (!sel_ok || m_cnt == TIMEOUT) begin
            m_mode = M_IDLE;
         end
      end
   endtask

   // Monitor: pops whatever the model predicted for this half-cycle.
   initial begin
      int            act, expk;
      bit            zchk, bad;
      logic [VW-1:0] epc;
      int            estr;
      exp_t          e;
      forever begin
         @(negedge clk);
         neg_idx++;
         act  = (sd_if.start_discovery_o   ? K_START   : 0)
              | (sd_if.confirm_discovery_o ? K_CONFIRM : 0)
              | (sd_if.infer_yumi_o        ? K_YUMI    : 0);
         expk = 0; zchk = 0; epc = '0; estr = 0;
         while (exp_q.size() > 0 && exp_q[0].idx < neg_idx) begin
            e = exp_q.pop_front();
            n_cmp++; n_err++;
            $display("FAIL missing_event kind=%0d due=%0d now=%0d", e.kind, e.idx, neg_idx);
         end
         while (exp_q.size() > 0 && exp_q[0].idx == neg_idx) begin
            e = exp_q.pop_front();
            if (e.kind == K_ZERO) zchk = 1'b1;
            else expk |= e.kind;
            if (e.kind == K_START || e.kind == K_CONFIRM) begin
               epc = e.pc; estr = e.stride;
            end
         end
         if (expk != 0 || act != 0 || zchk) begin
            n_cmp++;
            bad = (act != expk);
            if (!bad && (expk & (K_START | K_CONFIRM)) != 0)
               bad = (sd_if.striding_pc_o != epc) || (int'($signed(sd_io_stride())) != estr);
            if (zchk)
               bad = bad || (sd_if.striding_pc_o != '0) || (sd_if.stride_o != '0);
            if (bad) begin
               n_err++;
               $display("FAIL outputs t=%0d events got=%0d want=%0d pc got=%h want=%h stride got=%0d want=%0d zero_chk=%0d",
                        neg_idx, act, expk, sd_if.striding_pc_o, epc,
                        int'($signed(sd_io_stride())), estr, zchk);
            end
         end
      end
   end

   function automatic logic [SW-1:0] sd_io_stride();
      return sd_if.stride_o;
   endfunction

   longint pcs [6]         = '{64'h1000, 64'h1020, 64'h1004, 64'h2008, 64'h300C, 64'h1010};
   int     stride_pool [6] = '{8, -8, 16, -4, 4, 36864};
   longint cur [6];
   int     strd [6];

   initial begin
      int k, r, cont;
      bit ldv, iv, rst_now, mid_done, phase_a;
      reset_n         = 1'b0;
      sd_if.ld_v_i    = 1'b0;
      sd_if.ld_pc_i   = '0;
      sd_if.ld_vaddr_i = '0;
      sd_if.infer_v_i = 1'b0;
      mid_done        = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cur[i]  = (i == 0) ? 64'h100 : 64'h100000 + i * 64'h10000;
         strd[i] = (i == 3) ? -8 : 8;
      end
      for (int it = 0; it < N_ITER + 6; it++) begin
         @(posedge clk); #1;
         rst_now = (it < 2) || (it >= 3000 && !mid_done && m_mode == M_DISC);
         if (it >= 3000 && rst_now) mid_done = 1'b1;
         phase_a = ((it / 300) % 2) == 0;
         ldv = !rst_now && it < N_ITER && ($urandom_range(0, 3) != 0);
         iv  = !rst_now && ($urandom_range(0, 3) == 0);
         if (phase_a) k = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 5));
         else         k = ($urandom_range(0, 99) == 0) ? 0 : int'($urandom_range(2, 5));
         cont = (phase_a || k == 0) ? 80 : 20;
         if (ldv) begin
            r = int'($urandom_range(0, 99));
            if (r >= cont + 10) cur[k] = longint'($urandom_range(0, 1 << 24));
            else begin
               if (r >= cont) strd[k] = stride_pool[$urandom_range(0, 5)];
               if (cur[k] + strd[k] < 0) cur[k] = 64'h800000;
               cur[k] = cur[k] + strd[k];
            end
         end
         reset_n          = !rst_now;
         sd_if.ld_v_i     = ldv;
         sd_if.ld_pc_i    = VW'(pcs[k]);
         sd_if.ld_vaddr_i = VW'(cur[k]);
         sd_if.infer_v_i  = iv;
         model_step(!rst_now, ldv, pcs[k], cur[k], iv, neg_idx);
      end
      @(posedge clk); #1;
      sd_if.ld_v_i    = 1'b0;
      sd_if.infer_v_i = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain pending got=%0d want=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
